// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Retires BPC bits per cycle over N = XLEN/BPC cycles. Divide-by-zero and
// signed-overflow divides bypass the iteration and complete in one cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, sampled only in IDLE or DONE
//   funct3          M-extension operation select
//   op_a, op_b      rs1 / rs2 operands
//   rd_in           destination tag carried to rd_out
//   kill            flush; aborts any operation, wins over start
//   busy            stall request, high while iterating
//   done            one-cycle completion pulse; result/rd_out valid
//   result, rd_out  result and tag, held until the next done
//
// Handshake: a request is taken on a rising edge where start=1, kill=0 and
// the unit is in IDLE or DONE. Upstream must hold off while busy=1; a start
// seen during CALC is ignored, not queued.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  // hi: product high half / partial remainder
  // lo: multiplier being consumed / quotient being built
  // opnd: multiplicand (mul) or divisor (div), as a magnitude
  logic [XLEN-1:0] hi, lo, opnd;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3;
  logic            neg_res, neg_rem;
  logic [4:0]      rd_q;

  // Request decode
  logic            in_div, a_signed, b_signed, neg_a, neg_b;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  always_comb begin
    in_div   = funct3[2];
    // mul: MUL/MULH/MULHSU treat op_a as signed, only MUL/MULH op_b
    a_signed = in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = in_div ? ~funct3[0] : ~funct3[1];
    neg_a    = a_signed & op_a[XLEN-1];
    neg_b    = b_signed & op_b[XLEN-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    div_zero = in_div && (op_b == '0);
    div_ovf  = in_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_val = funct3[1] ? op_a : '1;
    else          special_val = funct3[1] ? '0 : op_a;
    accept   = start && !kill && (state == IDLE || state == DONE);
  end

  // One cycle of iteration: BPC single-bit steps chained combinationally.
  logic [XLEN-1:0] hi_step, lo_step;
  logic [XLEN:0]   t;

  always_comb begin
    hi_step = hi;
    lo_step = lo;
    t       = '0;
    for (int i = 0; i < BPC; i++) begin
      if (!f3[2]) begin
        // shift-add: conditionally add, then shift the 2*XLEN pair right
        t       = {1'b0, hi_step} + (lo_step[0] ? {1'b0, opnd} : '0);
        lo_step = {t[0], lo_step[XLEN-1:1]};
        hi_step = t[XLEN:1];
      end else begin
        // restoring division: trial-subtract the divisor from the shifted
        // remainder; the borrow bit decides the quotient bit
        t = {hi_step, lo_step[XLEN-1]} - {1'b0, opnd};
        if (!t[XLEN]) begin
          hi_step = t[XLEN-1:0];
          lo_step = {lo_step[XLEN-2:0], 1'b1};
        end else begin
          hi_step = {hi_step[XLEN-2:0], lo_step[XLEN-1]};
          lo_step = {lo_step[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  // Sign fix and result select, applied to the final iteration's output.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    prod = {hi_step, lo_step};
    if (neg_res) prod = -prod;
    quo = neg_res ? -lo_step : lo_step;
    rem = neg_rem ? -hi_step : hi_step;
    case (f3)
      3'b000:                fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fin = quo;
      default:               fin = rem;
    endcase
  end

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? (special ? DONE : CALC) : IDLE;
      CALC:       if (cnt == CW'(1)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      cnt     <= '0;
      f3      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      rd_q    <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else if (accept) begin
      f3      <= funct3;
      rd_q    <= rd_in;
      neg_res <= neg_a ^ neg_b;
      neg_rem <= neg_a;
      hi      <= '0;
      if (in_div) begin
        opnd <= mag_b;
        lo   <= mag_a;
      end else begin
        opnd <= mag_a;
        lo   <= mag_b;
      end
      if (special) begin
        cnt    <= '0;
        result <= special_val;
        rd_out <= rd_in;
      end else begin
        cnt <= CW'(N);
      end
    end else if (state == CALC) begin
      hi  <= hi_step;
      lo  <= lo_step;
      cnt <= cnt - 1'b1;
      // a kill on the last cycle leaves result/rd_out untouched
      if (state_next == DONE) begin
        result <= fin;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative RV32M/RV64M multiply/divide unit for the EX stage of the 5-stage pipeline. It executes all eight M-extension operations over several cycles. While it works, it raises a stall request so the hazard logic can freeze PC, IF/ID and ID/EX. A branch/jump flush from MEM can kill an in-flight operation.

## Interface
- XLEN, 32: operand/result width; must be a multiple of BPC.
- BPC, 1: bits retired per iteration (1, 2 or 4); sets the iteration count N = XLEN/BPC.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high; one clock, single clock domain.
- start  in  1  request; sampled only when the unit can accept (state IDLE or DONE).
- funct3  in  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value after forwarding.
- op_b  in  XLEN  rs2 value after forwarding.
- rd_in  in  5  destination tag, carried to rd_out.
- kill  in  1  flush; aborts any operation.
- busy  out  1  stall request; high in CALC.
- done  out  1  one-cycle pulse; result and rd_out valid.
- result  out  XLEN  operation result; held until the next done.
- rd_out  out  5  tag of the completed operation.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - Latch funct3, rd_in, |op_a|, |op_b| (magnitude only for signed operands, per funct3), and the result-sign flags.
  - Go to CALC with iteration counter = N.
  - Divide-by-zero and signed overflow (op_a = most-negative, op_b = all-ones, funct3 = 100/110) skip CALC and go straight to DONE.
- CALC:
  - Each cycle, process BPC bits and decrement the counter.
  - Counter reaches 0 → DONE.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring division over the quotient/remainder register pair.
- DONE:
  - Apply sign fix, drive result, pulse done.
  - start=1 is accepted as in IDLE (back-to-back); otherwise go to IDLE.
- Result selection:
  - MUL: low XLEN of the signed product.
  - MULH: high XLEN of signed×signed.
  - MULHSU: high XLEN of signed op_a × unsigned op_b.
  - MULHU: high XLEN of unsigned×unsigned.
  - DIV/REM: quotient is negated iff the operand signs differ; remainder takes the sign of op_a.
- Special cases (RISC-V spec):
  - Divide by zero: quotient = all-ones, remainder = op_a (signed and unsigned).
  - Signed overflow: quotient = op_a, remainder = 0.
- Arithmetic:
  - Multiply is modulo 2^(2*XLEN).
  - Sign negation is two's complement on the full product width before the half is selected.
- kill=1 in any state: next state IDLE, no done pulse, result/rd_out unchanged. kill has priority over start in the same cycle.
- start while in CALC is ignored; upstream must respect busy.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
- Normal latency: start sampled on edge 0 → busy=1 for cycles 1..N → done=1 in cycle N+1.
  - XLEN=32, BPC=1: done 33 cycles after start.
  - XLEN=32, BPC=4: done 9 cycles after start.
- Special-case latency: done in cycle 1; busy never asserts.
- busy deasserts in the same cycle done asserts. The EX stage captures result on that edge.
- Back-to-back:
  - A start in the DONE cycle begins a new CALC in the next cycle.
  - result and rd_out keep the old value until the new done.
- rst mid-operation: the next cycle matches the reset values; no done pulse.
- kill mid-CALC: busy=0 in the next cycle; a start is accepted in that cycle.

## Test plan
- XLEN=32, BPC=1: MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, done exactly 33 cycles after start, busy high for 32 cycles. MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases, each with done 1 cycle after start and busy never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Sequencing:
  - Start DIV, assert kill in CALC cycle 10: no done pulse, busy low the next cycle.
  - Start MUL in that cycle: it completes normally with its own rd_out.
  - Start asserted in a DONE cycle: the second result arrives 33 cycles later.
  - rst asserted mid-CALC: all outputs return to zero.
- XLEN=32, BPC=4: repeat the MUL/DIV vectors above; same results, done 9 cycles after start. Randomised 10k operations against a reference model, all funct3 values.
